keypad_emulator: RTL and testbench
==================================

# keypad_emulator

Synthesizable responder for the 4x4 keypad matrix. It sits where the physical keypad would be: it watches the active-low row drive from the keypad scanner and pulls the matching column low, exactly as a closed key switch would. It accepts one key press per request through a valid/ready handshake, holds the press for a programmed time, then releases it. This lets the scanner/debounce/combo chain run on the board or in simulation without a human pressing keys.

## Interface
- HOLD_CYCLES, 400000: cycles the key stays closed; must exceed the scanner's full 4-row sweep plus the debounce window.
- GAP_CYCLES, 400000: cycles the key stays open after release, before done.
- BOUNCE_CYCLES, 64: length of one bounce segment (used only with the bounce macro).
- BOUNCE_SEGS, 4: number of bounce segments; must be even and ≥2.
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- req_valid  in  1  press request
- req_ready  out  1  high only in IDLE
- req_key  in  4  key code; same encoding as the keyboard decoder
- row_n  in  4  active-low row drive from the scanner
- col_n  out  4  active-low column; 4'hF when open
- pressed  out  1  emulated switch is closed (press enable)
- busy  out  1  state ≠ IDLE
- done  out  1  one-cycle pulse when the gap ends

## Operation
- Key map (row index, column index 0..3):
  - row0: 1, 2, 3, A
  - row1: 4, 5, 6, B
  - row2: 7, 8, 9, C
  - row3: E(#), 0, F(*), D
- Every code 0–F maps to exactly one key.
- Handshake: a request is accepted on an edge where req_valid && req_ready. The block captures req_key and enters BOUNCE (when compiled in) or PRESS. req_valid while busy is ignored; it is not queued.
- States:
  - IDLE: waiting for a request.
  - BOUNCE (optional): see Configuration.
  - PRESS: counter runs HOLD_CYCLES cycles, then → GAP.
  - GAP: counter runs GAP_CYCLES cycles; on the last GAP cycle, done=1 and next state is IDLE.
- pressed=1 in PRESS and in enabled BOUNCE segments; 0 otherwise.
- Column drive is registered and updated every clk:
  - col_n <= (pressed && row_n[row_idx]==0) ? ~(4'b1 << col_idx) : 4'hF.
  - Wired-AND semantics: any low row bit equal to the target row closes the column. Other row bits are don't-care.
- Counter width is $clog2 of the maximum of HOLD_CYCLES, GAP_CYCLES and BOUNCE_CYCLES, plus 1. The counter loads N-1 and counts down to 0, so each phase lasts exactly N cycles.
- Reset:
  - State goes to IDLE; the counter is cleared.
  - col_n=4'hF, pressed=0, busy=0, done=0, req_ready=1 after the reset edge.
  - Reset mid-press releases the column on that same edge; no done is generated.

## Timing
- Accept at edge t: busy=1 and pressed=1 (PRESS case) from t+1.
- col_n can go low at t+2 at the earliest, and one cycle after row_n shows the target row.
- Without bounce: done is high during cycle t+HOLD_CYCLES+GAP_CYCLES. req_ready=1 from the next edge.
- Back-to-back: the earliest next accept is the edge immediately after done.
- col_n follows row_n changes with exactly one cycle of latency while pressed.

## Configuration
- KPEMU_BOUNCE_EN defined:
  - After accept, the BOUNCE state runs BOUNCE_SEGS segments of BOUNCE_CYCLES each.
  - pressed=1 in even segments and 0 in odd segments, then → PRESS.
  - Accept-to-done latency grows by BOUNCE_SEGS*BOUNCE_CYCLES.
- Undefined: the BOUNCE state and its logic are absent; accept goes directly to PRESS.

## Structure
- Package kpemu_pkg holds:
  - the state enum: IDLE, BOUNCE, PRESS, GAP;
  - the key-to-{row_idx, col_idx} function;
  - the KEY_OPEN=4'hF constant.
- Sub-module kpemu_matrix: registered column driver. Inputs are pressed, row_idx, col_idx and row_n; output is col_n. The top level holds the FSM and counter.

## Test plan
- Reset: assert rst for 2 cycles → col_n=F, req_ready=1, busy=0, pressed=0, done=0.
- Basic press (HOLD=20, GAP=10): key 5, row_n held 4'b1101 → col_n=4'b1101 from t+2 to t+21; done high at t+30; req_ready=1 from t+31.
- Scanning: key 5, row_n=4'b1110 → col_n stays F; row_n changes to 4'b1101 → col_n=4'b1101 one cycle later; row_n back to 4'b1110 → col_n=F one cycle later.
- Busy rejection: req_valid held during PRESS with key 9 → no second accept; key 9 is accepted only on the edge after done.
- Reset mid-press: rst during PRESS → col_n=F and state IDLE on the same edge; no done pulse.
- Integration with the keyboard scanner, debounce and combo at default parameters: keys 1, 2, 3, A in sequence → HEX3..HEX0 read "OPEN". With KPEMU_BOUNCE_EN defined, the same result and exactly one code latched per press.

Source files
------------

// File: rtl/kpemu_pkg.sv
// -----------------------------------------------------------------------------
// kpemu_pkg
// Shared types and helpers for the 4x4 keypad emulator.
//   state_e   : FSM states (BOUNCE is only reachable when KPEMU_BOUNCE_EN is
//               defined at compile time)
//   key_pos_t : {row index, column index} of a key in the matrix
//   KEY_OPEN  : column value when no switch is closed
//   key_pos() : key code -> matrix position, same encoding as the keyboard
//               decoder (E = '#', F = '*')
// -----------------------------------------------------------------------------
package kpemu_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BOUNCE = 2'd1,
    PRESS  = 2'd2,
    GAP    = 2'd3
  } state_e;

  typedef struct packed {
    logic [1:0] row;
    logic [1:0] col;
  } key_pos_t;

  localparam logic [3:0] KEY_OPEN = 4'hF;

  // Physical layout:
  //   row0: 1 2 3 A
  //   row1: 4 5 6 B
  //   row2: 7 8 9 C
  //   row3: # 0 * D
  function automatic key_pos_t key_pos(input logic [3:0] key);
    key_pos_t p;
    case (key)
      4'h1: p = '{row: 2'd0, col: 2'd0};
      4'h2: p = '{row: 2'd0, col: 2'd1};
      4'h3: p = '{row: 2'd0, col: 2'd2};
      4'hA: p = '{row: 2'd0, col: 2'd3};
      4'h4: p = '{row: 2'd1, col: 2'd0};
      4'h5: p = '{row: 2'd1, col: 2'd1};
      4'h6: p = '{row: 2'd1, col: 2'd2};
      4'hB: p = '{row: 2'd1, col: 2'd3};
      4'h7: p = '{row: 2'd2, col: 2'd0};
      4'h8: p = '{row: 2'd2, col: 2'd1};
      4'h9: p = '{row: 2'd2, col: 2'd2};
      4'hC: p = '{row: 2'd2, col: 2'd3};
      4'hE: p = '{row: 2'd3, col: 2'd0};
      4'h0: p = '{row: 2'd3, col: 2'd1};
      4'hF: p = '{row: 2'd3, col: 2'd2};
      default: p = '{row: 2'd3, col: 2'd3}; // 4'hD
    endcase
    return p;
  endfunction

endpackage

// File: rtl/keypad_emulator_if.sv
// -----------------------------------------------------------------------------
// keypad_emulator_if
// Request handshake, keypad matrix lines and status of the keypad emulator.
//   req_valid/req_ready/req_key : one key press per accepted request
//   row_n                       : active-low row drive from the scanner
//   col_n                       : active-low column answer (4'hF = open)
//   pressed/busy/done           : switch closed / not idle / gap finished pulse
// master = requester + scanner side, slave = emulator.
// -----------------------------------------------------------------------------
interface keypad_emulator_if;
  logic       req_valid;
  logic       req_ready;
  logic [3:0] req_key;
  logic [3:0] row_n;
  logic [3:0] col_n;
  logic       pressed;
  logic       busy;
  logic       done;

  modport master (
    output req_valid, req_key, row_n,
    input  req_ready, col_n, pressed, busy, done
  );

  modport slave (
    input  req_valid, req_key, row_n,
    output req_ready, col_n, pressed, busy, done
  );
endinterface

// File: rtl/kpemu_matrix.sv
// -----------------------------------------------------------------------------
// kpemu_matrix
// Registered column driver: behaves like one closed switch in a 4x4 matrix.
// Ports:
//   clk, rst      : clock, synchronous active-high reset (opens the column)
//   pressed_i     : emulated switch is closed
//   row_idx_i     : row of the emulated key
//   col_idx_i     : column of the emulated key
//   row_n_i       : active-low row drive from the scanner
//   col_n_o       : active-low column output, registered
// -----------------------------------------------------------------------------
module kpemu_matrix
  import kpemu_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       pressed_i,
  input  logic [1:0] row_idx_i,
  input  logic [1:0] col_idx_i,
  input  logic [3:0] row_n_i,
  output logic [3:0] col_n_o
);

  logic [3:0] col_n_q;
  logic [3:0] col_n_d;

  // Wired-AND: only the target row bit matters; other low rows are ignored.
  always_comb begin
    col_n_d = KEY_OPEN;
    if (pressed_i && !row_n_i[row_idx_i])
      col_n_d = ~(4'b0001 << col_idx_i);
  end

  // Reset opens the switch on the same edge, so a mid-press reset releases it.
  always_ff @(posedge clk) begin
    if (rst) col_n_q <= KEY_OPEN;
    else     col_n_q <= col_n_d;
  end

  assign col_n_o = col_n_q;

endmodule

// File: rtl/keypad_emulator.sv
// -----------------------------------------------------------------------------
// keypad_emulator
// Stands in for the physical 4x4 keypad: accepts one key press per request,
// keeps the switch closed for HOLD_CYCLES, open for GAP_CYCLES, then pulses
// done. The column answer is produced by kpemu_matrix from the scanner's rows.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   bus      : keypad_emulator_if.slave (request handshake, row_n/col_n,
//              pressed/busy/done)
// Compile-time option:
//   KPEMU_BOUNCE_EN : insert BOUNCE_SEGS contact-bounce segments of
//                     BOUNCE_CYCLES each (closed on even segments) before PRESS
// -----------------------------------------------------------------------------
module keypad_emulator
  import kpemu_pkg::*;
#(
  parameter int HOLD_CYCLES   = 400000,
  parameter int GAP_CYCLES    = 400000,
  parameter int BOUNCE_CYCLES = 64,
  parameter int BOUNCE_SEGS   = 4
) (
  input  logic               clk,
  input  logic               rst,
  keypad_emulator_if.slave   bus
);

  localparam int MAX_HG = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int MAX_C  = (MAX_HG > BOUNCE_CYCLES) ? MAX_HG : BOUNCE_CYCLES;
  localparam int CNT_W  = $clog2(MAX_C) + 1;

  localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LD  = CNT_W'(GAP_CYCLES - 1);

  // Bounce pattern must end on an open segment before the steady press.
  if (BOUNCE_SEGS < 2 || (BOUNCE_SEGS % 2) != 0) begin : g_bad_segs
    $error("BOUNCE_SEGS must be even and at least 2");
  end

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       key_q, key_d;
  logic             ready, busy, pressed, done;
  key_pos_t         pos;

`ifdef KPEMU_BOUNCE_EN
  localparam int                SEG_W  = $clog2(BOUNCE_SEGS) + 1;
  localparam logic [CNT_W-1:0]  BNC_LD = CNT_W'(BOUNCE_CYCLES - 1);
  localparam logic [SEG_W-1:0]  SEG_LAST = SEG_W'(BOUNCE_SEGS - 1);
  logic [SEG_W-1:0] seg_q, seg_d;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    key_d   = key_q;
    ready   = 1'b0;
    busy    = 1'b1;
    pressed = 1'b0;
    done    = 1'b0;
`ifdef KPEMU_BOUNCE_EN
    seg_d   = seg_q;
`endif
    case (state_q)
      IDLE: begin
        ready = 1'b1;
        busy  = 1'b0;
        if (bus.req_valid) begin
          key_d = bus.req_key;
`ifdef KPEMU_BOUNCE_EN
          state_d = BOUNCE;
          cnt_d   = BNC_LD;
          seg_d   = '0;
`else
          state_d = PRESS;
          cnt_d   = HOLD_LD;
`endif
        end
      end
`ifdef KPEMU_BOUNCE_EN
      BOUNCE: begin
        pressed = ~seg_q[0];
        if (cnt_q == '0) begin
          if (seg_q == SEG_LAST) begin
            state_d = PRESS;
            cnt_d   = HOLD_LD;
          end else begin
            seg_d = seg_q + 1'b1;
            cnt_d = BNC_LD;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
`endif
      PRESS: begin
        pressed = 1'b1;
        if (cnt_q == '0) begin
          state_d = GAP;
          cnt_d   = GAP_LD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      GAP: begin
        if (cnt_q == '0) begin
          done    = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
`ifdef KPEMU_BOUNCE_EN
      seg_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
`ifdef KPEMU_BOUNCE_EN
      seg_q   <= seg_d;
`endif
    end
  end

  // Captured key is only used outside IDLE, so it needs no reset.
  always_ff @(posedge clk) begin
    key_q <= key_d;
  end

  assign pos = key_pos(key_q);

  kpemu_matrix u_matrix (
    .clk       (clk),
    .rst       (rst),
    .pressed_i (pressed),
    .row_idx_i (pos.row),
    .col_idx_i (pos.col),
    .row_n_i   (bus.row_n),
    .col_n_o   (bus.col_n)
  );

  assign bus.req_ready = ready;
  assign bus.busy      = busy;
  assign bus.pressed   = pressed;
  assign bus.done      = done;

endmodule

// File: tb/tb_keypad_emulator.sv
// -----------------------------------------------------------------------------
// tb_keypad_emulator
// Drives keypad_emulator with directed and random requests and row patterns and
// compares every output each cycle against a timeline model: the model only
// tracks the number of cycles elapsed since the accepted request and derives
// the expected outputs from the phase lengths and the keypad layout table.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_keypad_emulator;

  localparam int HOLD = 20;
  localparam int GAP  = 10;
  localparam int BC   = 3;
  localparam int SEGS = 4;
`ifdef KPEMU_BOUNCE_EN
  localparam int BNC = SEGS * BC;
`else
  localparam int BNC = 0;
`endif
  localparam int TOTAL = BNC + HOLD + GAP;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  keypad_emulator_if bif ();

  keypad_emulator #(
    .HOLD_CYCLES   (HOLD),
    .GAP_CYCLES    (GAP),
    .BOUNCE_CYCLES (BC),
    .BOUNCE_SEGS   (SEGS)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Keypad layout as printed on the keys, row by row.
  logic [3:0] kmap [4][4] = '{
    '{4'h1, 4'h2, 4'h3, 4'hA},
    '{4'h4, 4'h5, 4'h6, 4'hB},
    '{4'h7, 4'h8, 4'h9, 4'hC},
    '{4'hE, 4'h0, 4'hF, 4'hD}
  };

  // Model state: cycles since accept (0 = idle), captured key, expected column.
  int         el = 0;
  logic [3:0] mkey = 4'h0;
  logic [3:0] col_exp = 4'hF;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit exp_pressed(input int e);
    if (e == 0) return 1'b0;
    if (e <= BNC) return (((e - 1) / BC) % 2) == 0;
    return e <= BNC + HOLD;
  endfunction

  function automatic void find_key(input logic [3:0] k, output int r, output int c);
    r = 0; c = 0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        if (kmap[i][j] == k) begin r = i; c = j; end
  endfunction

  // Apply inputs for one cycle, advance the model across the edge, then check.
  task automatic step(input logic r, input logic v, input logic [3:0] k, input logic [3:0] rown);
    int pr, pc;
    bit pcur;
    rst           = r;
    bif.req_valid = v;
    bif.req_key   = k;
    bif.row_n     = rown;
    @(posedge clk);
    pcur = exp_pressed(el);
    find_key(mkey, pr, pc);
    if (r) begin
      el      = 0;
      col_exp = 4'hF;
    end else begin
      col_exp = (pcur && rown[pr] == 1'b0) ? ~(4'b0001 << pc) : 4'hF;
      if (el == 0) begin
        if (v) begin el = 1; mkey = k; end
      end else if (el == TOTAL) el = 0;
      else el++;
    end
    @(negedge clk);
    chk("col_n",     32'(bif.col_n),     32'(col_exp));
    chk("pressed",   32'(bif.pressed),   32'(exp_pressed(el)));
    chk("busy",      32'(bif.busy),      32'(el != 0));
    chk("done",      32'(bif.done),      32'(el == TOTAL));
    chk("req_ready", 32'(bif.req_ready), 32'(el == 0));
  endtask

  initial begin
    logic [3:0] rn;
    rst = 1'b1;
    bif.req_valid = 1'b0;
    bif.req_key   = 4'h0;
    bif.row_n     = 4'hF;

    // Reset for two cycles.
    step(1, 0, 4'h0, 4'hF);
    step(1, 0, 4'h0, 4'hF);

    // Basic press: key 5 with its row held low.
    step(0, 1, 4'h5, 4'b1101);
    for (int i = 0; i < TOTAL + 3; i++) step(0, 0, 4'h0, 4'b1101);

    // Scanning: wrong row, then target row, then wrong row again.
    step(0, 1, 4'h5, 4'b1110);
    for (int i = 0; i < 4; i++) step(0, 0, 4'h0, 4'b1110);
    for (int i = 0; i < 3; i++) step(0, 0, 4'h0, 4'b1101);
    for (int i = 0; i < TOTAL; i++) step(0, 0, 4'h0, 4'b1110);

    // Busy rejection: key 9 requested continuously through the whole press.
    step(0, 1, 4'h5, 4'b1101);
    for (int i = 0; i < 2 * TOTAL + 6; i++) step(0, 1, 4'h9, 4'b1011);
    for (int i = 0; i < TOTAL; i++) step(0, 0, 4'h0, 4'b1011);

    // Reset mid-press: column released, no done afterwards.
    step(0, 1, 4'hD, 4'b0111);
    for (int i = 0; i < BNC + 5; i++) step(0, 0, 4'h0, 4'b0111);
    step(1, 0, 4'h0, 4'b0111);
    for (int i = 0; i < TOTAL + 4; i++) step(0, 0, 4'h0, 4'b0111);

    // Random traffic: mostly one-hot scanning rows, occasional arbitrary rows
    // and rare resets.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 3) != 0) rn = ~(4'b0001 << $urandom_range(0, 3));
      else                           rn = 4'($urandom_range(0, 15));
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) == 0),
           4'($urandom_range(0, 15)), rn);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
